// File: rtl/card_pkg.sv
// Shared card types, constants and the points rule used by the hand scorers.
package card_pkg;

   typedef logic [3:0] card_t;

   localparam card_t CARD_MIN  = 4'd1;
   localparam card_t CARD_MAX  = 4'd13;
   localparam int    SCORE_MOD = 10;

   // Pip cards 1..9 count at face value; 10..13 and an empty slot (0) count nothing.
   function automatic logic [3:0] card_points(input card_t c);
      return (c >= CARD_MIN && c <= 4'd9) ? c : 4'd0;
   endfunction

endpackage

// File: rtl/hand_scorer.sv
// Combinational modulo-10 score of one hand of CARDS_PER_HAND slots.
module hand_scorer
   import card_pkg::*;
#(
   parameter int CARDS_PER_HAND = 3
) (
   input  logic [CARDS_PER_HAND*4-1:0] hand_cards,
   output logic [3:0]                  hand_score
);

   logic [4:0] acc;

   // Running sum kept reduced after each card, so it never exceeds 18 before the fold.
   always_comb begin
      // NOTE: every variable written here gets a value on every path first;
      // otherwise synthesis infers a latch to hold the old value.
      acc = '0;
      for (int s = 0; s < CARDS_PER_HAND; s++) begin
         acc = acc + {1'b0, card_points(hand_cards[s*4 +: 4])};
         if (acc >= 5'(SCORE_MOD)) acc = acc - 5'(SCORE_MOD);
      end
      hand_score = acc[3:0];
   end

endmodule

// File: rtl/multi_hand_datapath.sv
// Multi-hand card datapath: free-running 1..13 deal counter, per-hand card
// slots with append/clear requests, deal ack/err pulses and registered scores.
module multi_hand_datapath
   import card_pkg::*;
#(
   parameter  int NUM_HANDS      = 2,
   parameter  int CARDS_PER_HAND = 3,
   localparam int HW             = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
   localparam int CW             = $clog2(CARDS_PER_HAND + 1)
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                deal_req,
   input  logic [HW-1:0]                       deal_hand,
   input  logic                                clear_req,
   input  logic [HW-1:0]                       clear_hand,
   output logic                                deal_ack,
   output logic                                deal_err,
   output logic [3:0]                          deal_card,
   output logic [NUM_HANDS*CARDS_PER_HAND*4-1:0] cards,
   output logic [NUM_HANDS*CW-1:0]             count,
   output logic [NUM_HANDS-1:0]                hand_full,
   output logic [NUM_HANDS*4-1:0]              score
);

   localparam logic [CW-1:0] FULL_COUNT = CW'(CARDS_PER_HAND);

   card_t         deal_ctr_q, deal_ctr_d;
   card_t         cards_q [NUM_HANDS][CARDS_PER_HAND];
   card_t         cards_d [NUM_HANDS][CARDS_PER_HAND];
   logic [CW-1:0] count_q [NUM_HANDS];
   logic [CW-1:0] count_d [NUM_HANDS];
   logic [3:0]    score_q [NUM_HANDS];
   logic [3:0]    score_d [NUM_HANDS];
   logic          deal_ack_q, deal_ack_d;
   logic          deal_err_q, deal_err_d;
   card_t         deal_card_q, deal_card_d;

   logic          clear_ok;
   logic          deal_ok;

   // Per-hand scorers read the current slots; their result is registered below.
   for (genvar h = 0; h < NUM_HANDS; h++) begin : g_hand
      logic [CARDS_PER_HAND*4-1:0] hand_flat;

      for (genvar s = 0; s < CARDS_PER_HAND; s++) begin : g_slot
         assign hand_flat[s*4 +: 4]                     = cards_q[h][s];
         assign cards[(h*CARDS_PER_HAND + s)*4 +: 4]    = cards_q[h][s];
      end

      hand_scorer #(
         .CARDS_PER_HAND(CARDS_PER_HAND)
      ) u_scorer (
         .hand_cards(hand_flat),
         .hand_score(score_d[h])
      );

      assign count[h*CW +: CW] = count_q[h];
      assign hand_full[h]      = (count_q[h] == FULL_COUNT);
      assign score[h*4 +: 4]   = score_q[h];
   end

   assign deal_ack  = deal_ack_q;
   assign deal_err  = deal_err_q;
   assign deal_card = deal_card_q;

   // Next-state: counter advance, deal accept/reject, and per-hand clear (clear wins on the same hand).
   always_comb begin
      cards_d     = cards_q;
      count_d     = count_q;
      deal_card_d = deal_card_q;
      deal_ack_d  = 1'b0;
      deal_err_d  = 1'b0;
      deal_ctr_d  = (deal_ctr_q == CARD_MAX) ? CARD_MIN : deal_ctr_q + 4'd1;

      clear_ok = clear_req && (int'(clear_hand) < NUM_HANDS);
      deal_ok  = 1'b0;
      for (int h = 0; h < NUM_HANDS; h++) begin
         if (deal_req && deal_hand == HW'(h)) begin
            deal_ok = (count_q[h] != FULL_COUNT) && !(clear_ok && clear_hand == deal_hand);
         end
      end

      if (deal_ok) begin
         for (int h = 0; h < NUM_HANDS; h++) begin
            if (deal_hand == HW'(h)) begin
               for (int s = 0; s < CARDS_PER_HAND; s++) begin
                  if (count_q[h] == CW'(s)) cards_d[h][s] = deal_ctr_q;
               end
               count_d[h] = count_q[h] + 1'b1;
            end
         end
         deal_ack_d  = 1'b1;
         deal_card_d = deal_ctr_q;
      end else if (deal_req) begin
         deal_err_d = 1'b1;
      end

      if (clear_ok) begin
         for (int h = 0; h < NUM_HANDS; h++) begin
            if (clear_hand == HW'(h)) begin
               for (int s = 0; s < CARDS_PER_HAND; s++) cards_d[h][s] = '0;
               count_d[h] = '0;
            end
         end
      end
   end

   // State registers, all cleared asynchronously by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         deal_ctr_q  <= CARD_MIN;
         deal_ack_q  <= 1'b0;
         deal_err_q  <= 1'b0;
         deal_card_q <= '0;
         // NOTE: these slot arrays are flops, not a RAM, and must read as empty
         // right after reset, so every entry is reset explicitly.
         for (int h = 0; h < NUM_HANDS; h++) begin
            count_q[h] <= '0;
            score_q[h] <= '0;
            for (int s = 0; s < CARDS_PER_HAND; s++) cards_q[h][s] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         deal_ctr_q  <= deal_ctr_d;
         deal_ack_q  <= deal_ack_d;
         deal_err_q  <= deal_err_d;
         deal_card_q <= deal_card_d;
         count_q     <= count_d;
         score_q     <= score_d;
         cards_q     <= cards_d;
      end
   end

endmodule

// File: tb/tb_multi_hand_datapath.sv
// Self-checking bench for multi_hand_datapath against a slot/queue-level model.
module tb_multi_hand_datapath;

   localparam int NH  = 2;
   localparam int CPH = 3;
   localparam int HW  = 1;
   localparam int CW  = 2;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  deal_req;
   logic [HW-1:0]         deal_hand;
   logic                  clear_req;
   logic [HW-1:0]         clear_hand;
   logic                  deal_ack;
   logic                  deal_err;
   logic [3:0]            deal_card;
   logic [NH*CPH*4-1:0]   cards;
   logic [NH*CW-1:0]      count;
   logic [NH-1:0]         hand_full;
   logic [NH*4-1:0]       score;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state
   int m_ctr;
   int m_cards [NH][CPH];
   int m_cnt   [NH];
   int m_score [NH];
   bit m_ack, m_err;
   int m_dcard;

   multi_hand_datapath #(.NUM_HANDS(NH), .CARDS_PER_HAND(CPH)) dut (
      .clk(clk), .reset(reset),
      .deal_req(deal_req), .deal_hand(deal_hand),
      .clear_req(clear_req), .clear_hand(clear_hand),
      .deal_ack(deal_ack), .deal_err(deal_err), .deal_card(deal_card),
      .cards(cards), .count(count), .hand_full(hand_full), .score(score)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_ctr = 1; m_ack = 0; m_err = 0; m_dcard = 0;
      for (int h = 0; h < NH; h++) begin
         m_cnt[h] = 0; m_score[h] = 0;
         for (int s = 0; s < CPH; s++) m_cards[h][s] = 0;
      end
   endtask

   function automatic int hand_points(int h);
      int sum = 0;
      for (int s = 0; s < CPH; s++) if (m_cards[h][s] <= 9) sum += m_cards[h][s];
      return sum % 10;
   endfunction

   function automatic logic [NH*CPH*4-1:0] exp_cards();
      logic [NH*CPH*4-1:0] v = '0;
      for (int h = 0; h < NH; h++)
         for (int s = 0; s < CPH; s++) v[(h*CPH+s)*4 +: 4] = 4'(m_cards[h][s]);
      return v;
   endfunction

   function automatic logic [NH*CW-1:0] exp_count();
      logic [NH*CW-1:0] v = '0;
      for (int h = 0; h < NH; h++) v[h*CW +: CW] = CW'(m_cnt[h]);
      return v;
   endfunction

   function automatic logic [NH-1:0] exp_full();
      logic [NH-1:0] v = '0;
      for (int h = 0; h < NH; h++) v[h] = (m_cnt[h] == CPH);
      return v;
   endfunction

   function automatic logic [NH*4-1:0] exp_score();
      logic [NH*4-1:0] v = '0;
      for (int h = 0; h < NH; h++) v[h*4 +: 4] = 4'(m_score[h]);
      return v;
   endfunction

   // Drive one edge of requests, advance the model, and leave time 1 unit after the edge.
   task automatic step(input bit dr, input int dh, input bit cr, input int ch);
      bit clear_hit, accept;
      deal_req = dr; deal_hand = HW'(dh); clear_req = cr; clear_hand = HW'(ch);
      @(posedge clk);
      for (int h = 0; h < NH; h++) m_score[h] = hand_points(h);
      clear_hit = cr && (ch < NH);
      accept    = dr && (dh < NH) && (m_cnt[dh] < CPH) && !(clear_hit && ch == dh);
      m_ack = accept;
      m_err = dr && !accept;
      if (accept) begin
         m_cards[dh][m_cnt[dh]] = m_ctr;
         m_cnt[dh]++;
         m_dcard = m_ctr;
      end
      if (clear_hit) begin
         for (int s = 0; s < CPH; s++) m_cards[ch][s] = 0;
         m_cnt[ch] = 0;
      end
      m_ctr = (m_ctr == 13) ? 1 : m_ctr + 1;
      #1;
      deal_req = 0; clear_req = 0;
   endtask

   task automatic test_reset();
      reset = 1; deal_req = 0; clear_req = 0; deal_hand = 0; clear_hand = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if ({deal_ack, deal_err, deal_card} !== 6'd0) begin
         n_fail++; $display("FAIL reset_ctl: ack/err/card got %b/%b/%0d expected 0/0/0", deal_ack, deal_err, deal_card);
      end
      n_cmp++; if (cards !== '0 || count !== '0 || score !== '0 || hand_full !== '0) begin
         n_fail++; $display("FAIL reset_state: cards=%h count=%h score=%h full=%b expected all zero", cards, count, score, hand_full);
      end
      @(negedge clk); reset = 0;
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 3; i++) begin
         step(1, 0, 0, 0);
         n_cmp++; if (deal_ack !== 1'b1 || deal_card !== 4'(i)) begin
            n_fail++; $display("FAIL fill_ack%0d: ack=%b card=%0d expected ack=1 card=%0d", i, deal_ack, deal_card, i);
         end
      end
      n_cmp++; if (count[CW-1:0] !== 2'd3 || hand_full[0] !== 1'b1 || cards !== exp_cards()) begin
         n_fail++; $display("FAIL fill_state: count0=%0d full0=%b cards=%h expected 3/1/%h", count[CW-1:0], hand_full[0], cards, exp_cards());
      end
      step(1, 0, 0, 0);
      n_cmp++; if (deal_err !== 1'b1 || deal_ack !== 1'b0 || deal_card !== 4'd3) begin
         n_fail++; $display("FAIL full_reject: err=%b ack=%b card=%0d expected 1/0/3", deal_err, deal_ack, deal_card);
      end
      n_cmp++; if (cards !== exp_cards() || count !== exp_count() || score[3:0] !== 4'd6) begin
         n_fail++; $display("FAIL full_state: cards=%h count=%h score0=%0d expected %h/%h/6", cards, count, score[3:0], exp_cards(), exp_count());
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 14 && m_ctr != 13; i++) step(0, 0, 0, 0);
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      n_cmp++; if (deal_card !== 4'd1 || cards[(1*CPH+0)*4 +: 4] !== 4'd13 || cards[(1*CPH+1)*4 +: 4] !== 4'd1) begin
         n_fail++; $display("FAIL wrap_cards: card=%0d slot0=%0d slot1=%0d expected 1/13/1", deal_card, cards[(1*CPH+0)*4 +: 4], cards[(1*CPH+1)*4 +: 4]);
      end
      step(0, 0, 0, 0);
      n_cmp++; if (score[7:4] !== 4'd1 || score !== exp_score()) begin
         n_fail++; $display("FAIL wrap_score: score=%h expected %h", score, exp_score());
      end
   endtask

   task automatic test_clear_collision();
      step(0, 0, 1, 1);
      for (int i = 0; i < 14 && m_ctr != 1; i++) step(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
      n_cmp++; if (cards[(1*CPH)*4 +: CPH*4] !== 12'h321) begin
         n_fail++; $display("FAIL redeal_cards: hand1=%h expected 321", cards[(1*CPH)*4 +: CPH*4]);
      end
      step(1, 1, 1, 1);
      n_cmp++; if (deal_err !== 1'b1 || deal_ack !== 1'b0 || cards[(1*CPH)*4 +: CPH*4] !== '0 || count[CW +: CW] !== '0) begin
         n_fail++; $display("FAIL same_hand_clear: err=%b ack=%b hand1=%h cnt1=%0d expected 1/0/0/0", deal_err, deal_ack, cards[(1*CPH)*4 +: CPH*4], count[CW +: CW]);
      end
      step(0, 0, 0, 0);
      n_cmp++; if (score[7:4] !== 4'd0 || score !== exp_score()) begin
         n_fail++; $display("FAIL clear_score: score=%h expected %h", score, exp_score());
      end
   endtask

   task automatic test_cross_clear();
      int v;
      v = m_ctr;
      step(1, 1, 1, 0);
      n_cmp++; if (deal_ack !== 1'b1 || deal_card !== 4'(v) || cards[CPH*4-1:0] !== '0 || cards[(1*CPH)*4 +: 4] !== 4'(v)) begin
         n_fail++; $display("FAIL cross_clear: ack=%b card=%0d hand0=%h h1s0=%0d expected 1/%0d/0/%0d", deal_ack, deal_card, cards[CPH*4-1:0], cards[(1*CPH)*4 +: 4], v, v);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, NH-1), $urandom_range(0, 5) == 0, $urandom_range(0, NH-1));
         n_cmp++;
         if (deal_ack !== m_ack || deal_err !== m_err || deal_card !== 4'(m_dcard) || cards !== exp_cards() ||
             count !== exp_count() || hand_full !== exp_full() || score !== exp_score()) begin
            n_fail++;
            $display("FAIL random_step%0d: ack=%b err=%b card=%0d cards=%h count=%h full=%b score=%h expected %b/%b/%0d/%h/%h/%b/%h",
                     i, deal_ack, deal_err, deal_card, cards, count, hand_full, score,
                     m_ack, m_err, m_dcard, exp_cards(), exp_count(), exp_full(), exp_score());
         end
      end
   endtask

   task automatic test_reset_mid();
      step(0, 0, 1, 0);
      step(0, 0, 1, 1);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      @(negedge clk);
      reset = 1;
      #1;
      model_reset();
      n_cmp++; if ({deal_ack, deal_err, deal_card} !== 6'd0 || cards !== '0 || count !== '0 || score !== '0) begin
         n_fail++; $display("FAIL reset_mid: ack=%b err=%b card=%0d cards=%h count=%h score=%h expected all zero", deal_ack, deal_err, deal_card, cards, count, score);
      end
      deal_req = 1; deal_hand = 0;
      @(posedge clk); #1;
      n_cmp++; if (deal_ack !== 1'b0 || deal_err !== 1'b0 || count !== '0) begin
         n_fail++; $display("FAIL reset_hold: ack=%b err=%b count=%h expected 0/0/0", deal_ack, deal_err, count);
      end
      deal_req = 0;
      @(negedge clk); reset = 0;
      step(1, 0, 0, 0);
      n_cmp++; if (deal_ack !== 1'b1 || deal_card !== 4'd1 || cards[3:0] !== 4'd1) begin
         n_fail++; $display("FAIL post_reset_deal: ack=%b card=%0d slot0=%0d expected 1/1/1", deal_ack, deal_card, cards[3:0]);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_wrap();
      test_clear_collision();
      test_cross_clear();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
